// File: rtl/adder_response_checker_if.sv
// -----------------------------------------------------------------------------
// adder_response_checker_if
// Bundles the stimulus/response handshake and the verdict outputs of the
// adder response checker.
//   master : stimulus source / bench side (drives i_*, observes o_*)
//   slave  : checker side (observes i_*, drives o_*)
// Signals:
//   i_start            one-cycle run start pulse
//   i_vld / o_rdy      vector transfer when both are high
//   i_a, i_b, i_cin    stimulus operands
//   i_sum, i_cout      adder response under test
//   o_busy, o_done     run in progress / run finished
//   o_pass             verdict, valid while o_done
//   o_pass_cnt         matching vectors this run
//   o_fail_cnt         mismatching vectors this run
//   o_first_fail_vld   at least one mismatch recorded
//   o_first_fail_idx   accept-order index of the first mismatch
// Optional macro ADDER_CHK_CAPTURE_EN adds o_first_fail_exp / o_first_fail_got.
// -----------------------------------------------------------------------------
interface adder_response_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             i_start;
  logic             i_vld;
  logic             o_rdy;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic [WIDTH-1:0] i_sum;
  logic             i_cout;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [CNT_W-1:0] o_pass_cnt;
  logic [CNT_W-1:0] o_fail_cnt;
  logic             o_first_fail_vld;
  logic [CNT_W-1:0] o_first_fail_idx;
`ifdef ADDER_CHK_CAPTURE_EN
  logic [WIDTH:0]   o_first_fail_exp;
  logic [WIDTH:0]   o_first_fail_got;
`endif

  modport master (
    output i_start, i_vld, i_a, i_b, i_cin, i_sum, i_cout,
    input  o_rdy, o_busy, o_done, o_pass, o_pass_cnt, o_fail_cnt,
           o_first_fail_vld, o_first_fail_idx
`ifdef ADDER_CHK_CAPTURE_EN
    , input o_first_fail_exp, o_first_fail_got
`endif
  );

  modport slave (
    input  i_start, i_vld, i_a, i_b, i_cin, i_sum, i_cout,
    output o_rdy, o_busy, o_done, o_pass, o_pass_cnt, o_fail_cnt,
           o_first_fail_vld, o_first_fail_idx
`ifdef ADDER_CHK_CAPTURE_EN
    , output o_first_fail_exp, o_first_fail_got
`endif
  );
endinterface

// File: rtl/adder_response_checker.sv
// -----------------------------------------------------------------------------
// adder_response_checker
// Checks {cout,sum} responses of a WIDTH-bit adder against a + b + cin, one
// compare stage after each accepted vector, and keeps per-run statistics.
// A run accepts NUM_VECTORS vectors, drains the compare stage, then reports.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  adder_response_checker_if.slave (handshake, operands, verdict)
// Optional macro ADDER_CHK_CAPTURE_EN: also latch expected/received values of
// the first mismatch on o_first_fail_exp / o_first_fail_got.
// -----------------------------------------------------------------------------
module adder_response_checker #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 16,
  parameter int NUM_VECTORS = 5
) (
  input logic                     clk,
  input logic                     rst,
  adder_response_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_NUM_VEC = CNT_W'(NUM_VECTORS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_run_start;
  logic             w_idx_last;
  logic             w_s1_match;
  logic [CNT_W-1:0] w_acc_idx_inc;
  logic [CNT_W-1:0] w_pass_cnt_nxt;
  logic [CNT_W-1:0] w_fail_cnt_nxt;

  logic             r_s1_vld;
  logic [WIDTH:0]   r_s1_exp;
  logic [WIDTH:0]   r_s1_got;
  logic [CNT_W-1:0] r_s1_idx;

  logic [CNT_W-1:0] r_acc_idx;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_pass;
  logic             r_ff_vld;
  logic [CNT_W-1:0] r_ff_idx;
`ifdef ADDER_CHK_CAPTURE_EN
  logic [WIDTH:0]   r_ff_exp;
  logic [WIDTH:0]   r_ff_got;
`endif

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Golden result, one bit wider than the operands so the carry is compared.
  function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             cin);
    golden = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Next-state logic and run-start / accept decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_start   = 1'b0;
    w_accept      = (r_state == ST_RUN) && bus.i_vld;
    w_acc_idx_inc = sat_inc(r_acc_idx);
    w_idx_last    = (w_acc_idx_inc == LP_NUM_VEC);
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          w_state_nxt = ST_RUN;
          w_run_start = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (w_accept && w_idx_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter updates produced by the compare stage.
  always_comb begin
    w_s1_match     = (r_s1_exp == r_s1_got);
    w_pass_cnt_nxt = r_pass_cnt;
    w_fail_cnt_nxt = r_fail_cnt;
    if (r_s1_vld) begin
      if (w_s1_match) begin
        w_pass_cnt_nxt = sat_inc(r_pass_cnt);
      end else begin
        w_fail_cnt_nxt = sat_inc(r_fail_cnt);
      end
    end else begin
      w_pass_cnt_nxt = r_pass_cnt;
      w_fail_cnt_nxt = r_fail_cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Compare stage S1: captures golden and received values on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_exp <= {(WIDTH+1){1'b0}};
      r_s1_got <= {(WIDTH+1){1'b0}};
      r_s1_idx <= {CNT_W{1'b0}};
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_exp <= golden(bus.i_a, bus.i_b, bus.i_cin);
        r_s1_got <= {bus.i_cout, bus.i_sum};
        r_s1_idx <= r_acc_idx;
      end
    end
  end

  // Run statistics, first-failure record and final verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_idx  <= {CNT_W{1'b0}};
      r_pass_cnt <= {CNT_W{1'b0}};
      r_fail_cnt <= {CNT_W{1'b0}};
      r_pass     <= 1'b0;
      r_ff_vld   <= 1'b0;
      r_ff_idx   <= {CNT_W{1'b0}};
`ifdef ADDER_CHK_CAPTURE_EN
      r_ff_exp   <= {(WIDTH+1){1'b0}};
      r_ff_got   <= {(WIDTH+1){1'b0}};
`endif
    end else if (w_run_start) begin
      // S1 is always empty in IDLE/DONE, so nothing in flight is lost here.
      r_acc_idx  <= {CNT_W{1'b0}};
      r_pass_cnt <= {CNT_W{1'b0}};
      r_fail_cnt <= {CNT_W{1'b0}};
      r_pass     <= 1'b0;
      r_ff_vld   <= 1'b0;
      r_ff_idx   <= {CNT_W{1'b0}};
`ifdef ADDER_CHK_CAPTURE_EN
      r_ff_exp   <= {(WIDTH+1){1'b0}};
      r_ff_got   <= {(WIDTH+1){1'b0}};
`endif
    end else begin
      if (w_accept) begin
        r_acc_idx <= w_acc_idx_inc;
      end
      r_pass_cnt <= w_pass_cnt_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      if (r_s1_vld && !w_s1_match && !r_ff_vld) begin
        r_ff_vld <= 1'b1;
        r_ff_idx <= r_s1_idx;
`ifdef ADDER_CHK_CAPTURE_EN
        r_ff_exp <= r_s1_exp;
        r_ff_got <= r_s1_got;
`endif
      end
      // Last compare retires on the DRAIN->DONE edge, so use its result.
      if (r_state == ST_DRAIN) begin
        r_pass <= (w_fail_cnt_nxt == {CNT_W{1'b0}});
      end
    end
  end

  assign bus.o_rdy            = (r_state == ST_RUN);
  assign bus.o_busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign bus.o_done           = (r_state == ST_DONE);
  assign bus.o_pass           = r_pass;
  assign bus.o_pass_cnt       = r_pass_cnt;
  assign bus.o_fail_cnt       = r_fail_cnt;
  assign bus.o_first_fail_vld = r_ff_vld;
  assign bus.o_first_fail_idx = r_ff_idx;
`ifdef ADDER_CHK_CAPTURE_EN
  assign bus.o_first_fail_exp = r_ff_exp;
  assign bus.o_first_fail_got = r_ff_got;
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_response_checker
// Self-checking bench for adder_response_checker (NUM_VECTORS=5 instance plus
// a NUM_VECTORS=1 instance). Expected statistics come from a reference model
// that scores each accepted vector with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_adder_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_response_checker_if #(.WIDTH(4), .CNT_W(16)) bus ();
  adder_response_checker_if #(.WIDTH(4), .CNT_W(16)) bus1 ();

  adder_response_checker #(.WIDTH(4), .CNT_W(16), .NUM_VECTORS(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  adder_response_checker #(.WIDTH(4), .CNT_W(16), .NUM_VECTORS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[5];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the current run.
  int   m_pass, m_fail, m_ffidx, m_idx;
  bit   m_ffvld;
  int   m_ffexp, m_ffgot;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_ffidx = 0; m_idx = 0; m_ffvld = 1'b0;
    m_ffexp = 0; m_ffgot = 0;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [3:0] b,
                              input logic c, input logic [4:0] resp);
    int e;
    e = int'(a) + int'(b) + int'(c);
    if (int'(resp) == e) begin
      m_pass++;
    end else begin
      m_fail++;
      if (!m_ffvld) begin
        m_ffvld = 1'b1; m_ffidx = m_idx; m_ffexp = e; m_ffgot = int'(resp);
      end
    end
    m_idx++;
  endtask

  task automatic start_run();
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  // Present one vector, wait (bounded) for rdy, transfer it, update the model.
  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [4:0] resp);
    int t;
    bus.i_a = a; bus.i_b = b; bus.i_cin = c;
    bus.i_sum = resp[3:0]; bus.i_cout = resp[4];
    bus.i_vld = 1'b1;
    t = 0;
    while (!bus.o_rdy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_rdy", bus.o_rdy, 1'b1);
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
    model_accept(a, b, c, resp);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pass_cnt"}, bus.o_pass_cnt, m_pass);
    chk({tag, "_fail_cnt"}, bus.o_fail_cnt, m_fail);
    chk({tag, "_ff_vld"}, bus.o_first_fail_vld, m_ffvld);
    chk({tag, "_ff_idx"}, bus.o_first_fail_idx, m_ffidx);
  endtask

  // Called one cycle after the last accept: state must be DRAIN, then DONE.
  task automatic finish_run(input string tag);
    chk({tag, "_drain_rdy"}, bus.o_rdy, 1'b0);
    chk({tag, "_drain_busy"}, bus.o_busy, 1'b1);
    chk({tag, "_drain_done"}, bus.o_done, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_done"}, bus.o_done, 1'b1);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_pass"}, bus.o_pass, (m_fail == 0));
    check_counts(tag);
`ifdef ADDER_CHK_CAPTURE_EN
    chk({tag, "_ff_exp"}, bus.o_first_fail_exp, m_ffexp);
    chk({tag, "_ff_got"}, bus.o_first_fail_got, m_ffgot);
`endif
  endtask

  // Table run with a gap cycle after each vector; bad_idx gets response 0.
  task automatic run_table(input string tag, input int bad_idx);
    logic [4:0] resp;
    model_clear();
    start_run();
    chk({tag, "_start_rdy"}, bus.o_rdy, 1'b1);
    chk({tag, "_start_pass"}, bus.o_pass, 1'b0);
    check_counts({tag, "_start"});
    for (int i = 0; i < 5; i++) begin
      resp = (i == bad_idx) ? 5'h00 : tbl[i].exp;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, resp);
      if (i < 4) begin
        @(posedge clk); #1;
        check_counts($sformatf("%s_v%0d", tag, i));
      end
    end
    finish_run(tag);
  endtask

  function automatic logic [4:0] good(input logic [3:0] a, input logic [3:0] b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[4:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] rr;
    int         acc;
    bit         exp_rdy;

    tbl[0] = '{4'h0, 4'h0, 1'b0, 5'h00};
    tbl[1] = '{4'h3, 4'h5, 1'b0, 5'h08};
    tbl[2] = '{4'hF, 4'h1, 1'b0, 5'h10};
    tbl[3] = '{4'hA, 4'h5, 1'b1, 5'h10};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 5'h1F};

    bus.i_start = 1'b0; bus.i_vld = 1'b0; bus.i_a = 4'h0; bus.i_b = 4'h0;
    bus.i_cin = 1'b0; bus.i_sum = 4'h0; bus.i_cout = 1'b0;
    bus1.i_start = 1'b0; bus1.i_vld = 1'b0; bus1.i_a = 4'h0; bus1.i_b = 4'h0;
    bus1.i_cin = 1'b0; bus1.i_sum = 4'h0; bus1.i_cout = 1'b0;
    model_clear();

    // Reset values.
    #1;
    chk("rst_rdy", bus.o_rdy, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_pass", bus.o_pass, 1'b0);
    check_counts("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_rdy", bus.o_rdy, 1'b0);

    // Golden run, then a run with vector 2 corrupted, then a clean rerun.
    run_table("golden", -1);
    run_table("bad2", 2);
    chk("bad2_fail_cnt_const", bus.o_fail_cnt, 16'd1);
    chk("bad2_ff_idx_const", bus.o_first_fail_idx, 16'd2);
`ifdef ADDER_CHK_CAPTURE_EN
    chk("bad2_ff_exp_const", bus.o_first_fail_exp, 5'h10);
    chk("bad2_ff_got_const", bus.o_first_fail_got, 5'h00);
`endif
    run_table("rerun", -1);

    // vld held high for 8 cycles with random vectors, some corrupted.
    model_clear();
    start_run();
    acc = 0;
    bus.i_vld = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rr = good(ra, rb, rc);
      if ($urandom_range(0, 2) == 0) rr = rr ^ 5'($urandom_range(1, 31));
      bus.i_a = ra; bus.i_b = rb; bus.i_cin = rc;
      bus.i_sum = rr[3:0]; bus.i_cout = rr[4];
      exp_rdy = (acc < 5);
      chk($sformatf("b2b_rdy_c%0d", cyc), bus.o_rdy, exp_rdy);
      if (exp_rdy) begin
        model_accept(ra, rb, rc, rr);
        acc++;
      end
      @(posedge clk); #1;
    end
    bus.i_vld = 1'b0;
    chk("b2b_done", bus.o_done, 1'b1);
    chk("b2b_pass", bus.o_pass, (m_fail == 0));
    chk("b2b_total", 32'(bus.o_pass_cnt) + 32'(bus.o_fail_cnt), 32'd5);
    check_counts("b2b");

    // start pulsed during RUN after 2 accepts is ignored.
    model_clear();
    start_run();
    for (int i = 0; i < 5; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rr = (i == 3) ? (good(ra, rb, rc) ^ 5'h10) : good(ra, rb, rc);
      send(ra, rb, rc, rr);
      if (i == 1) begin
        start_run();
        chk("midstart_busy", bus.o_busy, 1'b1);
        check_counts("midstart");
      end
    end
    finish_run("midstart_end");

    // Reset mid-run after the 3rd accept aborts immediately.
    model_clear();
    start_run();
    for (int i = 0; i < 3; i++) send(tbl[1].a, tbl[1].b, tbl[1].cin, 5'h00);
    rst = 1'b1;
    #1;
    model_clear();
    chk("mrst_rdy", bus.o_rdy, 1'b0);
    chk("mrst_busy", bus.o_busy, 1'b0);
    chk("mrst_done", bus.o_done, 1'b0);
    chk("mrst_pass", bus.o_pass, 1'b0);
    check_counts("mrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_idle_rdy", bus.o_rdy, 1'b0);
    run_table("after_rst", -1);

    // NUM_VECTORS=1 instance: one accept, then DRAIN, then DONE.
    chk("nv1_idle_rdy", bus1.o_rdy, 1'b0);
    bus1.i_start = 1'b1;
    @(posedge clk); #1;
    bus1.i_start = 1'b0;
    chk("nv1_run_rdy", bus1.o_rdy, 1'b1);
    bus1.i_a = 4'h7; bus1.i_b = 4'h8; bus1.i_cin = 1'b1;
    bus1.i_sum = 4'h0; bus1.i_cout = 1'b1;
    bus1.i_vld = 1'b1;
    @(posedge clk); #1;
    bus1.i_vld = 1'b0;
    chk("nv1_drain_rdy", bus1.o_rdy, 1'b0);
    chk("nv1_drain_busy", bus1.o_busy, 1'b1);
    chk("nv1_drain_done", bus1.o_done, 1'b0);
    @(posedge clk); #1;
    chk("nv1_done", bus1.o_done, 1'b1);
    chk("nv1_pass", bus1.o_pass, 1'b1);
    chk("nv1_pass_cnt", bus1.o_pass_cnt, 16'd1);
    chk("nv1_fail_cnt", bus1.o_fail_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
